// File: rtl/spi_regfile_slave_p.sv
// SPI-fed register file: frames carry R/W, address and data MSB first on spi_sclk.
// A local single-cycle read port and a sticky write-complete flag share the same clock.
module spi_regfile_slave_p #(
   parameter int unsigned ADDR_W   = 2,
   parameter int unsigned DATA_W   = 3,
   parameter int unsigned NUM_REGS = 4
) (
   input  logic              spi_sclk,
   input  logic              n_rst,
   input  logic              spi_ss_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   input  logic              r_en,
   input  logic [ADDR_W-1:0] r_addr,
   output logic [DATA_W-1:0] r_data,
   output logic              ren_ack,
   output logic              done,
   input  logic              done_sync2
);

   localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int unsigned CNT_W = $clog2(MAX_W + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);

   // State names the phase of the bit sampled on the most recent edge.
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WAIT} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                miso_q, miso_d;
   logic [DATA_W-1:0]   r_data_q, r_data_d;
   logic                ack_q, ack_d;
   logic                done_q, done_d;

   logic [DATA_W-1:0]   reg_file [NUM_REGS];
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;

   logic                addr_step;
   logic                data_step;
   logic [CNT_W-1:0]    step_cnt;
   logic [ADDR_W-1:0]   addr_shift;
   logic [DATA_W-1:0]   data_shift;
   logic [DATA_W-1:0]   spi_word;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < NUM_REGS;
   endfunction

   assign addr_shift = ADDR_W'({addr_q, spi_mosi});
   assign data_shift = DATA_W'({data_q, spi_mosi});
   assign spi_word   = in_range(addr_shift) ? reg_file[addr_shift] : '0;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] cell_q;
      always_ff @(posedge spi_sclk or negedge n_rst) begin
         if (!n_rst) begin
            cell_q <= '0;
         end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
            cell_q <= wr_data;
         end
      end
      assign reg_file[gi] = cell_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      data_d    = data_q;
      tx_d      = tx_q;
      miso_d    = miso_q;
      done_d    = done_q;
      r_data_d  = r_data_q;
      ack_d     = r_en;
      wr_en     = 1'b0;
      wr_addr   = addr_q;
      wr_data   = data_shift;
      addr_step = 1'b0;
      data_step = 1'b0;
      step_cnt  = '0;

      // Local read sees the array before any same-edge SPI write lands.
      if (r_en) begin
         r_data_d = in_range(r_addr) ? reg_file[r_addr] : '0;
      end
      if (done_sync2) begin
         done_d = 1'b0;
      end

      if (spi_ss_n) begin
         state_d = IDLE;
         cnt_d   = '0;
         tx_d    = '0;
         miso_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               rw_d    = spi_mosi;
               addr_d  = '0;
               data_d  = '0;
               cnt_d   = '0;
               miso_d  = 1'b0;
               state_d = CMD;
            end
            CMD: begin
               addr_step = 1'b1;
               step_cnt  = CNT_ONE;
               state_d   = ADDR;
            end
            ADDR: begin
               if (cnt_q != ADDR_LAST) begin
                  addr_step = 1'b1;
                  step_cnt  = cnt_q + CNT_ONE;
               end else begin
                  data_step = 1'b1;
                  step_cnt  = CNT_ONE;
                  state_d   = DATA;
               end
            end
            DATA: begin
               if (cnt_q != DATA_LAST) begin
                  data_step = 1'b1;
                  step_cnt  = cnt_q + CNT_ONE;
               end else begin
                  state_d = WAIT;
                  miso_d  = 1'b0;
               end
            end
            WAIT: begin
               miso_d = 1'b0;
            end
            default: begin
               state_d = IDLE;
               miso_d  = 1'b0;
            end
         endcase

         if (addr_step) begin
            addr_d = addr_shift;
            cnt_d  = step_cnt;
            // Read frames preload the MSB so it is on the line for the first data edge.
            if ((step_cnt == ADDR_LAST) && !rw_q) begin
               miso_d = spi_word[DATA_W-1];
               tx_d   = spi_word << 1;
            end
         end

         if (data_step) begin
            data_d = data_shift;
            cnt_d  = step_cnt;
            if (rw_q) begin
               if ((step_cnt == DATA_LAST) && in_range(addr_q)) begin
                  wr_en  = 1'b1;
                  done_d = 1'b1;
               end
            end else begin
               miso_d = (step_cnt == DATA_LAST) ? 1'b0 : tx_q[DATA_W-1];
               tx_d   = tx_q << 1;
            end
         end
      end
   end

   always_ff @(posedge spi_sclk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         tx_q     <= '0;
         miso_q   <= 1'b0;
         r_data_q <= '0;
         ack_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         tx_q     <= tx_d;
         miso_q   <= miso_d;
         r_data_q <= r_data_d;
         ack_q    <= ack_d;
         done_q   <= done_d;
      end
   end

   assign spi_miso = miso_q;
   assign r_data   = r_data_q;
   assign ren_ack  = ack_q;
   assign done     = done_q;

endmodule

// File: tb/tb_spi_regfile_slave_p.sv
// Directed bench for spi_regfile_slave_p: a default instance and a NUM_REGS=3 instance share stimulus.
// Local-read responses are scoreboarded per instance; frame-level outputs are checked inline.
module tb_spi_regfile_slave_p;

   logic       spi_sclk = 1'b0;
   logic       n_rst;
   logic       spi_ss_n;
   logic       spi_mosi;
   logic       r_en;
   logic [1:0] r_addr;
   logic       done_sync2;

   logic       spi_miso,  ren_ack,  done;
   logic [2:0] r_data;
   logic       spi_miso3, ren_ack3, done3;
   logic [2:0] r_data3;

   int errors = 0;
   int checks = 0;

   logic [2:0] exp_q[$];
   logic [2:0] exp3_q[$];
   logic [2:0] e_mon, e3_mon;
   logic [2:0] m, m3;

   always #5 spi_sclk = ~spi_sclk;

   spi_regfile_slave_p dut (
      .spi_sclk(spi_sclk), .n_rst(n_rst), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
      .ren_ack(ren_ack), .done(done), .done_sync2(done_sync2)
   );

   spi_regfile_slave_p #(.ADDR_W(2), .DATA_W(3), .NUM_REGS(3)) dut3 (
      .spi_sclk(spi_sclk), .n_rst(n_rst), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso3), .r_en(r_en), .r_addr(r_addr), .r_data(r_data3),
      .ren_ack(ren_ack3), .done(done3), .done_sync2(done_sync2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // Monitor: every acknowledge consumes one expected local-read value.
   always @(negedge spi_sclk) begin
      if (ren_ack) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ack_unexpected: ren_ack=1 with no read outstanding");
         end else begin
            e_mon = exp_q.pop_front();
            check("r_data", {29'd0, r_data}, {29'd0, e_mon});
         end
      end
      if (ren_ack3) begin
         if (exp3_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ack3_unexpected: ren_ack3=1 with no read outstanding");
         end else begin
            e3_mon = exp3_q.pop_front();
            check("r_data3", {29'd0, r_data3}, {29'd0, e3_mon});
         end
      end
   end

   task automatic tick();
      @(posedge spi_sclk);
      @(negedge spi_sclk);
   endtask

   task automatic gap(input logic ds);
      spi_ss_n = 1'b1; spi_mosi = 1'b0; done_sync2 = ds;
      tick();
      done_sync2 = 1'b0;
   endtask

   task automatic local_read(input logic [1:0] a, input logic [2:0] e, input logic [2:0] e3);
      r_en = 1'b1; r_addr = a;
      exp_q.push_back(e);
      exp3_q.push_back(e3);
      tick();
      r_en = 1'b0;
      tick();
      check("ack_one_cycle", {31'd0, ren_ack}, 32'd0);
   endtask

   // Drives edges first..last of a 6-bit frame; miso is captured after edges 3..5.
   task automatic frame(input logic [5:0] bits, input int first, input int last,
                        input int ren_at, input int ds_at);
      for (int e = first; e <= last; e++) begin
         spi_ss_n = 1'b0; spi_mosi = bits[6-e];
         r_en = (e == ren_at); done_sync2 = (e == ds_at);
         tick();
         r_en = 1'b0; done_sync2 = 1'b0;
         if (e >= 3 && e <= 5) begin
            m[5-e]  = spi_miso;
            m3[5-e] = spi_miso3;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
      r_en = 1'b0; r_addr = 2'd0; done_sync2 = 1'b0;
      m = '0; m3 = '0;
      repeat (2) @(negedge spi_sclk);
      check("rst_miso",    {31'd0, spi_miso}, 32'd0);
      check("rst_r_data",  {29'd0, r_data},   32'd0);
      check("rst_ack",     {31'd0, ren_ack},  32'd0);
      check("rst_done",    {31'd0, done},     32'd0);
      n_rst = 1'b1;
      tick();
      local_read(2'd2, 3'b000, 3'b000);

      // Write 1,10,101 then read it back locally.
      frame(6'b110101, 1, 6, 0, 0);
      check("wr_done",  {31'd0, done},     32'd1);
      check("wr_done3", {31'd0, done3},    32'd1);
      check("wr_miso",  {31'd0, spi_miso}, 32'd0);
      gap(1'b0);
      local_read(2'd2, 3'b101, 3'b101);

      // SPI read of reg 2.
      frame(6'b010000, 1, 6, 0, 0);
      check("rd_bits",      {29'd0, m},        32'b101);
      check("rd_bits3",     {29'd0, m3},       32'b101);
      check("rd_miso_end",  {31'd0, spi_miso}, 32'd0);
      check("rd_done_keep", {31'd0, done},     32'd1);
      gap(1'b0);
      local_read(2'd2, 3'b101, 3'b101);

      gap(1'b1);
      check("clr_done",  {31'd0, done},  32'd0);
      check("clr_done3", {31'd0, done3}, 32'd0);

      // Abort after four bits of a write to reg 1.
      frame(6'b101100, 1, 4, 0, 0);
      gap(1'b0);
      check("abort_done", {31'd0, done},     32'd0);
      check("abort_miso", {31'd0, spi_miso}, 32'd0);
      local_read(2'd1, 3'b000, 3'b000);

      // Clear request coinciding with completion loses to the set.
      frame(6'b101011, 1, 6, 0, 6);
      check("set_wins",  {31'd0, done},  32'd1);
      check("set_wins3", {31'd0, done3}, 32'd1);
      gap(1'b1);
      check("clr_after",  {31'd0, done},  32'd0);
      check("clr_after3", {31'd0, done3}, 32'd0);
      local_read(2'd1, 3'b011, 3'b011);

      // Address 3 exists only in the default instance.
      frame(6'b111110, 1, 6, 0, 0);
      check("a3_done",  {31'd0, done},  32'd1);
      check("a3_done3", {31'd0, done3}, 32'd0);
      gap(1'b0);
      frame(6'b011000, 1, 6, 0, 0);
      check("a3_bits",  {29'd0, m},  32'b110);
      check("a3_bits3", {29'd0, m3}, 32'b000);
      gap(1'b0);
      local_read(2'd3, 3'b110, 3'b000);

      // Local read on the write-completion edge returns the old value.
      r_addr = 2'd0;
      exp_q.push_back(3'b000);
      exp3_q.push_back(3'b000);
      frame(6'b100111, 1, 6, 6, 0);
      check("same_edge_done3", {31'd0, done3}, 32'd1);
      gap(1'b0);
      local_read(2'd0, 3'b111, 3'b111);

      // Asynchronous reset in the middle of the data phase.
      frame(6'b110010, 1, 4, 0, 0);
      check("pre_rst_done",   {31'd0, done},   32'd1);
      check("pre_rst_r_data", {29'd0, r_data}, 32'b111);
      #2 n_rst = 1'b0;
      #1;
      check("async_miso",   {31'd0, spi_miso}, 32'd0);
      check("async_r_data", {29'd0, r_data},   32'd0);
      check("async_ack",    {31'd0, ren_ack},  32'd0);
      check("async_done",   {31'd0, done},     32'd0);
      check("async_done3",  {31'd0, done3},    32'd0);
      @(negedge spi_sclk);
      spi_ss_n = 1'b1;
      @(negedge spi_sclk);
      n_rst = 1'b1;
      tick();
      local_read(2'd2, 3'b000, 3'b000);
      frame(6'b110010, 1, 6, 0, 0);
      check("post_rst_done", {31'd0, done}, 32'd1);
      gap(1'b0);
      local_read(2'd2, 3'b010, 3'b010);

      repeat (3) tick();
      check("sb_drained",  exp_q.size(),  32'd0);
      check("sb3_drained", exp3_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
